// File: rtl/error_line_buffer.sv
// rtl/error_line_buffer.sv - inter-line error store/replay for the error-diffusion path
// Optional feature macro: ERR_LINE_DECAY_EN (attenuate every stored error by v - (v >>> 3)).
module error_line_buffer #(
  parameter int ERROR_BITS = 9,
  parameter int MAX_WIDTH  = 2048,
  parameter int ADDR_BITS  = $clog2(MAX_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  line_start,
  output logic                  ready,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [ERROR_BITS-1:0] kern_err_r,
  input  logic [ERROR_BITS-1:0] kern_err_bl,
  input  logic [ERROR_BITS-1:0] kern_err_b,
  input  logic [ERROR_BITS-1:0] kern_err_br,
  output logic [ERROR_BITS-1:0] err_line_out,
  output logic [ERROR_BITS-1:0] err_left_out,
  output logic [ERROR_BITS-1:0] err_bottom_left_out,
  output logic [ERROR_BITS-1:0] err_bottom_out,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  // Pixel index space is one bit wider than the RAM address so that indices
  // at or past MAX_WIDTH stay distinguishable; the counter saturates at
  // MAX_WIDTH+1 so the FLUSH stage can still tell an out-of-range last pixel.
  localparam logic [ADDR_BITS:0] LIMIT = (ADDR_BITS+1)'(MAX_WIDTH);
  localparam logic [ADDR_BITS:0] X_SAT = (ADDR_BITS+1)'(MAX_WIDTH + 1);

  logic [ERROR_BITS-1:0] mem [MAX_WIDTH];

  state_t                state_q, state_d;
  logic [ADDR_BITS:0]    x_q, x_d;
  logic [ERROR_BITS-1:0] line_q, line_d;
  logic [ERROR_BITS-1:0] left_q, left_d;
  logic [ERROR_BITS-1:0] bl_q, bl_d;
  logic [ERROR_BITS-1:0] bot_q, bot_d;
  logic                  ovf_q, ovf_d;
  logic                  first_q, first_d;

  logic                  rd_en;
  logic [ADDR_BITS:0]    rd_idx;
  logic                  wr_en;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [ERROR_BITS-1:0] wr_val;
  logic [ERROR_BITS-1:0] wr_data;

  // Value actually committed to the line RAM.
  function automatic logic [ERROR_BITS-1:0] store_val(input logic [ERROR_BITS-1:0] v);
`ifdef ERR_LINE_DECAY_EN
    logic signed [ERROR_BITS-1:0] s;
    s = $signed(v) >>> 3;
    return v - s;
`else
    return v;
`endif
  endfunction

  // Next-state, feedback capture, RAM read/write request and flag updates.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    line_d  = line_q;
    left_d  = left_q;
    bl_d    = bl_q;
    bot_d   = bot_q;
    ovf_d   = ovf_q;
    first_d = first_q;
    rd_en   = 1'b0;
    rd_idx  = '0;
    wr_en   = 1'b0;
    wr_addr = ADDR_BITS'(x_q - 1'b1);
    wr_val  = kern_err_bl;

    if (line_start) begin
      // Start (or abort and restart) a line; no flush of a partial line.
      state_d = ACTIVE;
      x_d     = '0;
      left_d  = '0;
      bl_d    = '0;
      bot_d   = '0;
      rd_en   = 1'b1;
      rd_idx  = '0;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (in_valid) begin
            left_d = kern_err_r;
            bl_d   = kern_err_b;
            bot_d  = kern_err_br;
            x_d    = (x_q >= LIMIT) ? X_SAT : x_q + 1'b1;
            rd_en  = 1'b1;
            rd_idx = x_q + 1'b1;
            // Pixel 0 has no left neighbour to finalise.
            wr_en  = (x_q != '0) && (x_q < LIMIT);
            wr_val = kern_err_bl;
            if (x_q >= LIMIT) ovf_d = 1'b1;
            if (in_last) state_d = FLUSH;
          end
        end
        FLUSH: begin
          // Last pixel's bottom error is final once the line ends.
          wr_en   = (x_q <= LIMIT);
          wr_val  = bl_q;
          state_d = IDLE;
          first_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (frame_start) begin
      first_d = 1'b1;
      ovf_d   = 1'b0;
    end

    if (rd_en) begin
      line_d = (first_d || rd_idx >= LIMIT) ? '0 : mem[rd_idx[ADDR_BITS-1:0]];
    end

    wr_data = store_val(wr_val);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      line_q  <= '0;
      left_q  <= '0;
      bl_q    <= '0;
      bot_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      line_q  <= line_d;
      left_q  <= left_d;
      bl_q    <= bl_d;
      bot_q   <= bot_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
    end
  end

  // Line RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign ready               = (state_q == ACTIVE);
  assign err_line_out        = line_q;
  assign err_left_out        = left_q;
  assign err_bottom_left_out = bl_q;
  assign err_bottom_out      = bot_q;
  assign overflow            = ovf_q;

endmodule

// File: tb/tb_error_line_buffer.sv
// tb/tb_error_line_buffer.sv - directed self-checking bench for error_line_buffer
module tb_error_line_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start, line_start, in_valid, in_last;
  logic [8:0] kern_err_r, kern_err_bl, kern_err_b, kern_err_br;

  logic       ready, overflow;
  logic [8:0] line_o, left_o, bl_o, bot_o;
  logic       ready4, overflow4;
  logic [8:0] line4, left4, bl4, bot4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  error_line_buffer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .ready(ready), .in_valid(in_valid), .in_last(in_last),
    .kern_err_r(kern_err_r), .kern_err_bl(kern_err_bl), .kern_err_b(kern_err_b),
    .kern_err_br(kern_err_br), .err_line_out(line_o), .err_left_out(left_o),
    .err_bottom_left_out(bl_o), .err_bottom_out(bot_o), .overflow(overflow)
  );

  error_line_buffer #(.MAX_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .ready(ready4), .in_valid(in_valid), .in_last(in_last),
    .kern_err_r(kern_err_r), .kern_err_bl(kern_err_bl), .kern_err_b(kern_err_b),
    .kern_err_br(kern_err_br), .err_line_out(line4), .err_left_out(left4),
    .err_bottom_left_out(bl4), .err_bottom_out(bot4), .overflow(overflow4)
  );

  // Expected stored value of a written error.
  function automatic logic [8:0] dec(input int v);
    int r;
`ifdef ERR_LINE_DECAY_EN
    r = v - (v >>> 3);
`else
    r = v;
`endif
    return r[8:0];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic fs);
    line_start = 1'b1; frame_start = fs;
    tick();
    line_start = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pix(input int bl, input int b, input int br, input int r, input logic last);
    in_valid = 1'b1; in_last = last;
    kern_err_bl = 9'(bl); kern_err_b = 9'(b); kern_err_br = 9'(br); kern_err_r = 9'(r);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_start = 0; line_start = 0; in_valid = 0; in_last = 0;
    kern_err_r = 0; kern_err_bl = 0; kern_err_b = 0; kern_err_br = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if ({line_o, left_o, bl_o, bot_o} !== 36'd0) begin errors++; $display("FAIL reset_outs got %h exp 0", {line_o, left_o, bl_o, bot_o}); end
    checks++; if (overflow !== 1'b0 || overflow4 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b%b exp 00", overflow, overflow4); end
  endtask

  task automatic test_first_line();
    int bl[4] = '{5, 6, 7, 8};
    int b[4]  = '{1, 2, 3, 4};
    int r[4]  = '{-3, 21, 22, 23};
    start(1'b1);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL l1_ready got %b exp 1", ready); end
    checks++; if (line_o !== 9'd0) begin errors++; $display("FAIL l1_line_start got %h exp 0", line_o); end
    for (int i = 0; i < 4; i++) begin
      pix(bl[i], b[i], 10 + i, r[i], i == 3);
      checks++; if (line_o !== 9'd0) begin errors++; $display("FAIL l1_line_px%0d got %h exp 0", i, line_o); end
      checks++; if (left_o !== 9'(r[i]) || bl_o !== 9'(b[i]) || bot_o !== 9'(10 + i)) begin
        errors++; $display("FAIL l1_fb_px%0d got %h %h %h exp %h %h %h", i, left_o, bl_o, bot_o, 9'(r[i]), 9'(b[i]), 9'(10 + i));
      end
    end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL l1_flush_ready got %b exp 0", ready); end
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL l1_idle_ready got %b exp 0", ready); end
  endtask

  task automatic test_second_line();
    int bl[4] = '{99, 16, -9, 33};
    logic [8:0] e[4];
    e[0] = dec(7); e[1] = dec(8); e[2] = dec(4); e[3] = 9'd0;
    start(1'b0);
    checks++; if (line_o !== dec(6)) begin errors++; $display("FAIL l2_line_start got %h exp %h", line_o, dec(6)); end
    checks++; if (left_o !== 9'd0 || bl_o !== 9'd0 || bot_o !== 9'd0) begin errors++; $display("FAIL l2_fb_clear got %h %h %h exp 0", left_o, bl_o, bot_o); end
    for (int i = 0; i < 4; i++) begin
      pix(bl[i], 40 + i, i, 0, i == 3);
      if (i < 3) begin
        checks++; if (line_o !== e[i]) begin errors++; $display("FAIL l2_line_px%0d got %h exp %h", i, line_o, e[i]); end
      end
      checks++; if (line4 !== e[i]) begin errors++; $display("FAIL l2_line4_px%0d got %h exp %h", i, line4, e[i]); end
    end
    tick();
  endtask

  task automatic test_abort();
    start(1'b0);
    checks++; if (line_o !== dec(16)) begin errors++; $display("FAIL ab_line_start got %h exp %h", line_o, dec(16)); end
    pix(0, 0, 0, 0, 1'b0);
    checks++; if (line_o !== dec(-9)) begin errors++; $display("FAIL ab_line_px0 got %h exp %h", line_o, dec(-9)); end
    pix(50, 55, 56, 57, 1'b0);
    checks++; if (line_o !== dec(33)) begin errors++; $display("FAIL ab_line_px1 got %h exp %h", line_o, dec(33)); end
    tick();
    checks++; if (line_o !== dec(33) || left_o !== 9'd57) begin errors++; $display("FAIL ab_bubble_hold got %h %h exp %h 039", line_o, left_o, dec(33)); end
    start(1'b0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ab_restart_ready got %b exp 1", ready); end
    checks++; if (line_o !== dec(50) || left_o !== 9'd0) begin errors++; $display("FAIL ab_restart got %h %h exp %h 000", line_o, left_o, dec(50)); end
    pix(60, 70, 0, 0, 1'b0);
    checks++; if (line_o !== dec(-9)) begin errors++; $display("FAIL ab_noflush got %h exp %h", line_o, dec(-9)); end
    pix(61, 71, 0, 0, 1'b0);
    checks++; if (line_o !== dec(33)) begin errors++; $display("FAIL ab_px1 got %h exp %h", line_o, dec(33)); end
    pix(62, 72, 0, 0, 1'b0);
    checks++; if (line_o !== dec(43)) begin errors++; $display("FAIL ab_px2 got %h exp %h", line_o, dec(43)); end
    pix(63, 73, 0, 0, 1'b1);
    tick();
  endtask

  task automatic test_overflow();
    logic [8:0] e[3];
    e[0] = dec(62); e[1] = dec(63); e[2] = dec(73);
    start(1'b0);
    checks++; if (line4 !== dec(61)) begin errors++; $display("FAIL ov_line_start got %h exp %h", line4, dec(61)); end
    for (int i = 0; i < 6; i++) begin
      pix(80 + i, 90 + i, 0, 0, i == 5);
      if (i < 3) begin
        checks++; if (line4 !== e[i]) begin errors++; $display("FAIL ov_line4_px%0d got %h exp %h", i, line4, e[i]); end
      end
      if (i == 3) begin
        checks++; if (overflow4 !== 1'b0 || line4 !== 9'd0) begin errors++; $display("FAIL ov_px3 got %b %h exp 0 000", overflow4, line4); end
      end
      if (i == 4) begin
        checks++; if (overflow4 !== 1'b1 || line4 !== 9'd0) begin errors++; $display("FAIL ov_px4 got %b %h exp 1 000", overflow4, line4); end
      end
    end
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ov_wide_ovf got %b exp 0", overflow); end
    start(1'b0);
    checks++; if (line_o !== dec(81) || line4 !== dec(81)) begin errors++; $display("FAIL ov_rb_start got %h %h exp %h", line_o, line4, dec(81)); end
    pix(0, 0, 0, 0, 1'b0);
    pix(0, 0, 0, 0, 1'b0);
    checks++; if (line4 !== dec(83)) begin errors++; $display("FAIL ov_rb_px1 got %h exp %h", line4, dec(83)); end
    pix(0, 0, 0, 0, 1'b0);
    checks++; if (line4 !== dec(73)) begin errors++; $display("FAIL ov_mem3_kept got %h exp %h", line4, dec(73)); end
    checks++; if (line_o !== dec(84)) begin errors++; $display("FAIL ov_wide_mem3 got %h exp %h", line_o, dec(84)); end
    pix(0, 0, 0, 0, 1'b1);
    tick();
    checks++; if (overflow4 !== 1'b1) begin errors++; $display("FAIL ov_sticky got %b exp 1", overflow4); end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    checks++; if (overflow4 !== 1'b0) begin errors++; $display("FAIL ov_clear got %b exp 0", overflow4); end
  endtask

  task automatic test_new_frame_and_reset();
    start(1'b0);
    checks++; if (line_o !== 9'd0 || ready !== 1'b1) begin errors++; $display("FAIL nf_first_line got %h %b exp 000 1", line_o, ready); end
    pix(0, 0, 0, 77, 1'b0);
    checks++; if (line_o !== 9'd0 || left_o !== 9'd77) begin errors++; $display("FAIL nf_px0 got %h %h exp 000 04d", line_o, left_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b0 || left_o !== 9'd0) begin errors++; $display("FAIL midline_reset got %b %h exp 0 000", ready, left_o); end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_second_line();
    test_abort();
    test_overflow();
    test_new_frame_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/error_line_buffer.md
# error_line_buffer

Stores and replays the inter-line error of the error-diffusion path. It sits between the error diffusion kernel and a simple dual-port line RAM. Per pixel, it does three things:
- captures the kernel's right, bottom-left, bottom and bottom-right error outputs;
- closes the 3-tap accumulation across neighbouring pixels and writes finished below-row errors to RAM;
- on the next line, plays those errors back aligned with the pixel stream, together with the registered left/bottom feedback the kernel needs.

## Interface
- ERROR_BITS, 9: signed error width, two's complement, 8.1 fixed point
- MAX_WIDTH, 2048: line RAM depth in pixels
- ADDR_BITS, 11: clog2(MAX_WIDTH)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  pulse; the next line is the first line of the frame
- line_start  in  1  pulse; begins a line and issues the RAM read of address 0
- ready  out  1  high when the block accepts a pixel
- in_valid  in  1  one pixel processed by the kernel this cycle; ignored while ready=0
- in_last  in  1  qualifies in_valid; marks the last pixel of the line
- kern_err_r  in  ERROR_BITS  kernel right error for pixel x
- kern_err_bl  in  ERROR_BITS  kernel bottom-left output; final value for pixel x-1
- kern_err_b  in  ERROR_BITS  kernel bottom output; partial value for pixel x
- kern_err_br  in  ERROR_BITS  kernel bottom-right output; partial value for pixel x+1
- err_line_out  out  ERROR_BITS  stored error for the current pixel; drives kernel err_line_buffer_in
- err_left_out  out  ERROR_BITS  registered kern_err_r; drives kernel err_left_in
- err_bottom_left_out  out  ERROR_BITS  registered kern_err_b; drives kernel err_bottom_left_in
- err_bottom_out  out  ERROR_BITS  registered kern_err_br; drives kernel err_bottom_in
- overflow  out  1  sticky: a pixel arrived at index >= MAX_WIDTH

## Operation
- States: IDLE, ACTIVE, FLUSH. ready = (state==ACTIVE).
- IDLE + line_start -> ACTIVE. On that edge:
  - pixel counter x := 0;
  - all three feedback registers := 0;
  - RAM read address 0 issued.
- ACTIVE + in_valid:
  - feedback registers load kern_err_r, kern_err_b, kern_err_br;
  - x increments;
  - RAM read address x+1 is issued, so the next value is ready one cycle later;
  - if x>0, write mem[x-1] := kern_err_bl; at x=0 the write is suppressed (there is no left neighbour);
  - with in_last: the state goes to FLUSH, and the last kern_err_b is already captured in err_bottom_left_out's register.
- FLUSH, one cycle: write mem[x_last] := registered kern_err_b, then go to IDLE. The last pixel's kern_err_br is discarded (off the right edge).
- First line of the frame:
  - a first_line flag is set by frame_start and cleared on FLUSH exit;
  - while it is set, err_line_out reads 0 regardless of RAM contents.
- In-place reuse: the read of address x always precedes the write of address x-1 in the next line, so a single RAM holds one line.
- Index x >= MAX_WIDTH: the RAM write is dropped, err_line_out=0, and overflow sets. overflow clears only on frame_start.
- line_start in ACTIVE or FLUSH aborts the current line. There is no flush; the block restarts at x=0 as if from IDLE.
- frame_start and line_start in the same cycle: both take effect.
- All RAM values are passed through unchanged (the kernel has already clamped them to ERROR_BITS).

## Timing
- Reset values: state=IDLE, ready=0, err_line_out=0, err_left_out=0, err_bottom_left_out=0, err_bottom_out=0, overflow=0, first_line=1.
- RAM contents are not cleared by reset; the first-line forcing covers this.
- line_start at cycle t -> ready=1 at t+1, and err_line_out = mem[0] at t+1.
- Zero-bubble throughput: in_valid may be high on every cycle while ready=1.
- Outputs are stable until the next accepted in_valid.
- Write latency: mem[x-1] is written on the same edge that accepts pixel x.
- in_last accepted at t -> ready=0 at t+1 (FLUSH) and t+2 (IDLE).
- The earliest following line_start is at t+2.
- Reset asserted mid-line returns the block to IDLE immediately; no partial flush happens.

## Configuration
- ERR_LINE_DECAY_EN defined: every RAM write stores v - (v>>>3), an arithmetic shift truncating toward minus infinity. This attenuates accumulated error and suppresses worm artifacts.
- Not defined: values are written unchanged.

## Test plan
- Reset, then frame_start + line_start, then 4 pixels with kern_err_bl=5,6,7,8, kern_err_b=1,2,3,4 and in_last on pixel 3 -> mem[0..3]=6,7,8,4; err_line_out=0 throughout (first line).
- Second line, same width -> err_line_out=6,7,8,4 on consecutive accepted cycles with in_valid held high.
- kern_err_r=-3 (9'h1FD) on pixel 0 -> err_left_out=9'h1FD at pixel 1; err_left_out=0 at pixel 0 of every line.
- line_start issued while ACTIVE at x=2 -> no FLUSH write, x restarts at 0, ready stays 1 from the next cycle.
- MAX_WIDTH=4 with a 6-pixel line -> overflow=1 after pixel 4; mem[3] unchanged by pixels 4 and 5; overflow clears on frame_start.
- With ERR_LINE_DECAY_EN, kern_err_bl=16 and -9 -> stored 14 and -7.
